// File: rtl/tl_ul_arb2.sv
// Two-to-one TileLink-UL arbiter: round-robin A-channel grant with stall lock,
// source-tag D-channel routing and per-client in-flight throttling.
module tl_ul_arb2 #(
    parameter int SRC_W        = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               in0_a_valid,
    output logic               in0_a_ready,
    input  logic [2:0]         in0_a_opcode,
    input  logic [2:0]         in0_a_param,
    input  logic [3:0]         in0_a_size,
    input  logic [SRC_W-1:0]   in0_a_source,
    input  logic [13:0]        in0_a_address,
    input  logic [3:0]         in0_a_mask,
    input  logic [31:0]        in0_a_data,
    input  logic               in0_a_corrupt,

    input  logic               in1_a_valid,
    output logic               in1_a_ready,
    input  logic [2:0]         in1_a_opcode,
    input  logic [2:0]         in1_a_param,
    input  logic [3:0]         in1_a_size,
    input  logic [SRC_W-1:0]   in1_a_source,
    input  logic [13:0]        in1_a_address,
    input  logic [3:0]         in1_a_mask,
    input  logic [31:0]        in1_a_data,
    input  logic               in1_a_corrupt,

    output logic               out_a_valid,
    input  logic               out_a_ready,
    output logic [2:0]         out_a_opcode,
    output logic [2:0]         out_a_param,
    output logic [3:0]         out_a_size,
    output logic [SRC_W:0]     out_a_source,
    output logic [13:0]        out_a_address,
    output logic [3:0]         out_a_mask,
    output logic [31:0]        out_a_data,
    output logic               out_a_corrupt,

    input  logic               out_d_valid,
    output logic               out_d_ready,
    input  logic [2:0]         out_d_opcode,
    input  logic [1:0]         out_d_param,
    input  logic [3:0]         out_d_size,
    input  logic [SRC_W:0]     out_d_source,
    input  logic               out_d_denied,
    input  logic [31:0]        out_d_data,
    input  logic               out_d_corrupt,

    output logic               in0_d_valid,
    input  logic               in0_d_ready,
    output logic [2:0]         in0_d_opcode,
    output logic [1:0]         in0_d_param,
    output logic [3:0]         in0_d_size,
    output logic [SRC_W-1:0]   in0_d_source,
    output logic               in0_d_denied,
    output logic [31:0]        in0_d_data,
    output logic               in0_d_corrupt,

    output logic               in1_d_valid,
    input  logic               in1_d_ready,
    output logic [2:0]         in1_d_opcode,
    output logic [1:0]         in1_d_param,
    output logic [3:0]         in1_d_size,
    output logic [SRC_W-1:0]   in1_d_source,
    output logic               in1_d_denied,
    output logic [31:0]        in1_d_data,
    output logic               in1_d_corrupt,

    output logic               d_orphan
);

    localparam logic [3:0] MaxCnt = 4'(MAX_INFLIGHT);

    logic       rr_ptr_q, rr_ptr_d;
    logic       lock_q, lock_d;
    logic       lock_idx_q, lock_idx_d;
    logic [3:0] cnt0_q, cnt0_d;
    logic [3:0] cnt1_q, cnt1_d;
    logic       d_orphan_q, d_orphan_d;

    logic elig0_s, elig1_s, sel_s, sel_elig_s;
    logic a_fire_s, a_stall_s, d_idx_s, d_fire_s;
    logic inc0_s, inc1_s, dec0_s, dec1_s;

    // Simultaneous A and D fire on one client leave its count unchanged.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc,
                                            input logic dec);
        if (inc && !dec) begin
            return cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            return cnt - 4'd1;
        end else begin
            return cnt;
        end
    endfunction

    // Grant selection: a stalled grant is held, otherwise round-robin among eligible
    always_comb begin
        elig0_s = in0_a_valid && (cnt0_q < MaxCnt);
        elig1_s = in1_a_valid && (cnt1_q < MaxCnt);
        if (lock_q) begin
            sel_s = lock_idx_q;
        end else if (elig0_s && elig1_s) begin
            sel_s = rr_ptr_q;
        end else if (elig1_s) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        sel_elig_s = sel_s ? elig1_s : elig0_s;
    end

    // A-channel mux; the A side is held quiet while reset is asserted
    always_comb begin
        out_a_valid = sel_elig_s && !reset;
        in0_a_ready = 1'b0;
        in1_a_ready = 1'b0;
        if (sel_s) begin
            in1_a_ready   = out_a_ready && sel_elig_s && !reset;
            out_a_opcode  = in1_a_opcode;
            out_a_param   = in1_a_param;
            out_a_size    = in1_a_size;
            out_a_source  = {1'b1, in1_a_source};
            out_a_address = in1_a_address;
            out_a_mask    = in1_a_mask;
            out_a_data    = in1_a_data;
            out_a_corrupt = in1_a_corrupt;
        end else begin
            in0_a_ready   = out_a_ready && sel_elig_s && !reset;
            out_a_opcode  = in0_a_opcode;
            out_a_param   = in0_a_param;
            out_a_size    = in0_a_size;
            out_a_source  = {1'b0, in0_a_source};
            out_a_address = in0_a_address;
            out_a_mask    = in0_a_mask;
            out_a_data    = in0_a_data;
            out_a_corrupt = in0_a_corrupt;
        end
    end

    // D-channel routing by the tag bit; fields broadcast to both clients
    always_comb begin
        d_idx_s       = out_d_source[SRC_W];
        in0_d_valid   = out_d_valid && !d_idx_s;
        in1_d_valid   = out_d_valid && d_idx_s;
        out_d_ready   = d_idx_s ? in1_d_ready : in0_d_ready;
        in0_d_opcode  = out_d_opcode;
        in1_d_opcode  = out_d_opcode;
        in0_d_param   = out_d_param;
        in1_d_param   = out_d_param;
        in0_d_size    = out_d_size;
        in1_d_size    = out_d_size;
        in0_d_source  = out_d_source[SRC_W-1:0];
        in1_d_source  = out_d_source[SRC_W-1:0];
        in0_d_denied  = out_d_denied;
        in1_d_denied  = out_d_denied;
        in0_d_data    = out_d_data;
        in1_d_data    = out_d_data;
        in0_d_corrupt = out_d_corrupt;
        in1_d_corrupt = out_d_corrupt;
    end

    // Next-state: pointer, lock, in-flight counters and orphan detection
    always_comb begin
        a_fire_s  = out_a_valid && out_a_ready;
        a_stall_s = out_a_valid && !out_a_ready;
        d_fire_s  = out_d_valid && out_d_ready;
        inc0_s    = a_fire_s && !sel_s;
        inc1_s    = a_fire_s && sel_s;
        dec0_s    = d_fire_s && !d_idx_s;
        dec1_s    = d_fire_s && d_idx_s;

        rr_ptr_d   = a_fire_s ? ~sel_s : rr_ptr_q;
        lock_d     = a_stall_s;
        lock_idx_d = a_stall_s ? sel_s : lock_idx_q;
        cnt0_d     = cnt_next(cnt0_q, inc0_s, dec0_s);
        cnt1_d     = cnt_next(cnt1_q, inc1_s, dec1_s);
        d_orphan_d = d_orphan_q
                   | (dec0_s && (cnt0_q == 4'd0) && !inc0_s)
                   | (dec1_s && (cnt1_q == 4'd0) && !inc1_s);
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            cnt0_q     <= 4'd0;
            cnt1_q     <= 4'd0;
            d_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            d_orphan_q <= d_orphan_d;
        end
    end

    assign d_orphan = d_orphan_q;

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Self-checking bench for tl_ul_arb2: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_tl_ul_arb2;

    logic clock, reset;

    logic [1:0]  a_valid, a_ready, a_corrupt;
    logic [2:0]  a_opcode [2];
    logic [2:0]  a_param [2];
    logic [3:0]  a_size [2];
    logic [3:0]  a_mask [2];
    logic [4:0]  a_source [2];
    logic [13:0] a_address [2];
    logic [31:0] a_data [2];

    logic        out_a_valid, out_a_ready, out_a_corrupt;
    logic [2:0]  out_a_opcode, out_a_param;
    logic [3:0]  out_a_size, out_a_mask;
    logic [5:0]  out_a_source;
    logic [13:0] out_a_address;
    logic [31:0] out_a_data;

    logic        d_valid, out_d_ready, d_denied, d_corrupt;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [5:0]  d_source;
    logic [31:0] d_data;

    logic [1:0]  ind_valid, ind_ready, ind_denied, ind_corrupt;
    logic [2:0]  ind_opcode [2];
    logic [1:0]  ind_param [2];
    logic [3:0]  ind_size [2];
    logic [4:0]  ind_source [2];
    logic [31:0] ind_data [2];
    logic        d_orphan;

    int checks = 0;
    int errors = 0;

    tl_ul_arb2 #(.SRC_W(5), .MAX_INFLIGHT(4)) dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(a_valid[0]), .in0_a_ready(a_ready[0]), .in0_a_opcode(a_opcode[0]),
        .in0_a_param(a_param[0]), .in0_a_size(a_size[0]), .in0_a_source(a_source[0]),
        .in0_a_address(a_address[0]), .in0_a_mask(a_mask[0]), .in0_a_data(a_data[0]),
        .in0_a_corrupt(a_corrupt[0]),
        .in1_a_valid(a_valid[1]), .in1_a_ready(a_ready[1]), .in1_a_opcode(a_opcode[1]),
        .in1_a_param(a_param[1]), .in1_a_size(a_size[1]), .in1_a_source(a_source[1]),
        .in1_a_address(a_address[1]), .in1_a_mask(a_mask[1]), .in1_a_data(a_data[1]),
        .in1_a_corrupt(a_corrupt[1]),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_a_corrupt(out_a_corrupt),
        .out_d_valid(d_valid), .out_d_ready(out_d_ready), .out_d_opcode(d_opcode),
        .out_d_param(d_param), .out_d_size(d_size), .out_d_source(d_source),
        .out_d_denied(d_denied), .out_d_data(d_data), .out_d_corrupt(d_corrupt),
        .in0_d_valid(ind_valid[0]), .in0_d_ready(ind_ready[0]), .in0_d_opcode(ind_opcode[0]),
        .in0_d_param(ind_param[0]), .in0_d_size(ind_size[0]), .in0_d_source(ind_source[0]),
        .in0_d_denied(ind_denied[0]), .in0_d_data(ind_data[0]), .in0_d_corrupt(ind_corrupt[0]),
        .in1_d_valid(ind_valid[1]), .in1_d_ready(ind_ready[1]), .in1_d_opcode(ind_opcode[1]),
        .in1_d_param(ind_param[1]), .in1_d_size(ind_size[1]), .in1_d_source(ind_source[1]),
        .in1_d_denied(ind_denied[1]), .in1_d_data(ind_data[1]), .in1_d_corrupt(ind_corrupt[1]),
        .d_orphan(d_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clr;
        a_valid = 2'b00; a_corrupt = 2'b00; out_a_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            a_opcode[c] = 3'd0; a_param[c] = 3'd0; a_size[c] = 4'd2; a_mask[c] = 4'hF;
            a_source[c] = 5'd0; a_address[c] = 14'd0; a_data[c] = 32'd0;
        end
        d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; d_opcode = 3'd0;
        d_param = 2'd0; d_size = 4'd2; d_source = 6'd0; d_data = 32'd0;
        ind_ready = 2'b00;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clr();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clr();
        #2;
        checks++;
        if (out_a_valid !== 1'b0 || a_ready !== 2'b00 || ind_valid !== 2'b00 || d_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got av=%b ar=%b dv=%b orph=%b required 0 0 0 0",
                     out_a_valid, a_ready, ind_valid, d_orphan);
        end
        tick(); tick();
        reset = 1'b0;
        #2;
        checks++;
        if (out_a_valid !== 1'b0 || a_ready !== 2'b00 || d_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got av=%b ar=%b orph=%b required 0 0 0",
                     out_a_valid, a_ready, d_orphan);
        end
    endtask

    task automatic test_round_robin;
        logic exp;
        do_reset();
        a_valid = 2'b11; out_a_ready = 1'b1; d_valid = 1'b1; ind_ready = 2'b11;
        a_source[0] = 5'h03; a_source[1] = 5'h11;
        for (int i = 0; i < 8; i++) begin
            exp = 1'(i % 2);
            d_source = {exp, 5'h00};
            #2;
            checks++;
            if (out_a_source !== {exp, (exp ? 5'h11 : 5'h03)}) begin
                errors++;
                $display("FAIL rr_grant cyc=%0d got=%h required=%h", i, out_a_source,
                         {exp, (exp ? 5'h11 : 5'h03)});
            end
            tick();
        end
        clr();
        #2;
        checks++;
        if (d_orphan !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_orphan got=%b required=0", d_orphan);
        end
    endtask

    task automatic test_stall;
        do_reset();
        a_valid = 2'b10; a_source[1] = 5'h07; a_address[1] = 14'h0040;
        a_source[0] = 5'h1A; a_address[0] = 14'h1234;
        for (int c = 0; c < 4; c++) begin
            if (c >= 1) a_valid[0] = 1'b1;
            out_a_ready = (c == 3);
            #2;
            checks++;
            if (out_a_valid !== 1'b1 || out_a_source !== 6'h27 || out_a_address !== 14'h0040
                || a_ready !== {(c == 3), 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b src=%h addr=%h rdy=%b required 1 27 0040 %b",
                         c, out_a_valid, out_a_source, out_a_address, a_ready, {(c == 3), 1'b0});
            end
            tick();
        end
        a_valid[1] = 1'b0;
        #2;
        checks++;
        if (out_a_source !== 6'h1A || a_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_after got src=%h rdy=%b required 1a 01", out_a_source, a_ready);
        end
        clr();
    endtask

    task automatic test_throttle;
        do_reset();
        a_valid = 2'b01; out_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (a_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL throttle_accept n=%0d got=%b required=1", i, a_ready[0]);
            end
            tick();
        end
        #2;
        checks++;
        if (a_ready[0] !== 1'b0 || out_a_valid !== 1'b0) begin
            errors++;
            $display("FAIL throttle_block got rdy=%b v=%b required 0 0", a_ready[0], out_a_valid);
        end
        a_valid = 2'b11;
        #2;
        checks++;
        if (out_a_source[5] !== 1'b1 || a_ready !== 2'b10) begin
            errors++;
            $display("FAIL throttle_other got idx=%b rdy=%b required 1 10", out_a_source[5], a_ready);
        end
        tick();
        a_valid = 2'b01; d_valid = 1'b1; d_source = 6'h00; ind_ready = 2'b01;
        #2;
        checks++;
        if (out_d_ready !== 1'b1 || ind_valid !== 2'b01 || a_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL throttle_dfire got drdy=%b dv=%b ardy=%b required 1 01 0",
                     out_d_ready, ind_valid, a_ready[0]);
        end
        tick();
        d_valid = 1'b0;
        #2;
        checks++;
        if (a_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL throttle_release got=%b required=1", a_ready[0]);
        end
        tick();
        a_valid = 2'b00; out_a_ready = 1'b0;
    endtask

    // Relies on client 1 holding one outstanding request from test_throttle.
    task automatic test_d_route;
        d_valid = 1'b1; d_source = 6'h25; d_data = 32'hDEADBEEF; ind_ready = 2'b01;
        #2;
        checks++;
        if (ind_valid !== 2'b10 || ind_source[1] !== 5'h05 || ind_data[1] !== 32'hDEADBEEF
            || out_d_ready !== 1'b0) begin
            errors++;
            $display("FAIL droute_stalled got dv=%b src=%h data=%h rdy=%b required 10 05 deadbeef 0",
                     ind_valid, ind_source[1], ind_data[1], out_d_ready);
        end
        tick();
        ind_ready = 2'b10;
        #2;
        checks++;
        if (out_d_ready !== 1'b1 || ind_valid !== 2'b10) begin
            errors++;
            $display("FAIL droute_ready got rdy=%b dv=%b required 1 10", out_d_ready, ind_valid);
        end
        tick();
        clr();
        #2;
        checks++;
        if (d_orphan !== 1'b0) begin
            errors++;
            $display("FAIL droute_no_orphan got=%b required=0", d_orphan);
        end
    endtask

    task automatic test_orphan;
        do_reset();
        d_valid = 1'b1; d_source = 6'h00; ind_ready = 2'b01;
        tick();
        d_valid = 1'b0;
        #2;
        checks++;
        if (d_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set got=%b required=1", d_orphan);
        end
        a_valid = 2'b01; out_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (a_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL orphan_cnt_zero n=%0d got=%b required=1", i, a_ready[0]);
            end
            tick();
        end
        #2;
        checks++;
        if (a_ready[0] !== 1'b0 || d_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky got rdy=%b orph=%b required 0 1", a_ready[0], d_orphan);
        end
        clr();
    endtask

    task automatic test_reset_mid;
        do_reset();
        a_valid = 2'b10; out_a_ready = 1'b1;
        tick(); tick();
        out_a_ready = 1'b0;
        tick();
        a_valid = 2'b11;
        #2;
        checks++;
        if (out_a_source[5] !== 1'b1 || out_a_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_locked got idx=%b v=%b required 1 1", out_a_source[5], out_a_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_a_valid !== 1'b0 || a_ready !== 2'b00) begin
            errors++;
            $display("FAIL rmid_async got v=%b rdy=%b required 0 00", out_a_valid, a_ready);
        end
        tick(); tick();
        reset = 1'b0; out_a_ready = 1'b1;
        #2;
        checks++;
        if (out_a_valid !== 1'b1 || out_a_source[5] !== 1'b0) begin
            errors++;
            $display("FAIL rmid_first_grant got v=%b idx=%b required 1 0", out_a_valid, out_a_source[5]);
        end
        tick();
        a_valid = 2'b00; d_valid = 1'b1; d_source = 6'h20; ind_ready = 2'b10;
        tick();
        d_valid = 1'b0;
        #2;
        checks++;
        if (d_orphan !== 1'b1) begin
            errors++;
            $display("FAIL rmid_orphan got=%b required=1", d_orphan);
        end
        a_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (a_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL rmid_cnt_cleared n=%0d got=%b required=1", i, a_ready[1]);
            end
            tick();
        end
        #2;
        checks++;
        if (a_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cnt_limit got=%b required=0", a_ready[1]);
        end
        clr();
    endtask

    // Reference model: outstanding counts per client, last granted client,
    // client whose stalled request must be presented again, sticky orphan flag.
    task automatic test_random;
        int  cnt [2];
        int  last, held, win, idx;
        bit  orphan, ev, dv, afire, dfire;
        bit  elig [2];
        int  old [2];
        do_reset();
        cnt[0] = 0; cnt[1] = 0; last = 1; held = -1; orphan = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                a_valid[c]   = ($urandom_range(0, 3) != 0);
                a_opcode[c]  = 3'($urandom); a_param[c] = 3'($urandom);
                a_size[c]    = 4'($urandom); a_mask[c] = 4'($urandom);
                a_source[c]  = 5'($urandom); a_address[c] = 14'($urandom);
                a_data[c]    = $urandom; a_corrupt[c] = 1'($urandom);
            end
            out_a_ready = ($urandom_range(0, 3) != 0);
            dv = (cnt[0] > 0 || cnt[1] > 0) && ($urandom_range(0, 1) == 1);
            if (cnt[0] > 0 && cnt[1] > 0) idx = int'($urandom_range(0, 1));
            else idx = (cnt[1] > 0) ? 1 : 0;
            d_valid = dv; d_source = {1'(idx), 5'($urandom)};
            d_data = $urandom; d_opcode = 3'($urandom); d_param = 2'($urandom);
            d_size = 4'($urandom); d_denied = 1'($urandom); d_corrupt = 1'($urandom);
            ind_ready = 2'($urandom);
            #2;
            for (int c = 0; c < 2; c++) elig[c] = a_valid[c] && (cnt[c] < 4);
            if (held >= 0) win = held;
            else if (elig[0] && elig[1]) win = (last == 0) ? 1 : 0;
            else win = elig[1] ? 1 : 0;
            ev = elig[win];
            checks++;
            if (out_a_valid !== ev) begin
                errors++;
                $display("FAIL rand_a_valid cyc=%0d got=%b required=%b", cyc, out_a_valid, ev);
            end
            if (ev) begin
                checks++;
                if (out_a_source !== {1'(win), a_source[win]} || out_a_address !== a_address[win]
                    || out_a_data !== a_data[win] || out_a_mask !== a_mask[win]) begin
                    errors++;
                    $display("FAIL rand_a_fields cyc=%0d got src=%h addr=%h required src=%h addr=%h",
                             cyc, out_a_source, out_a_address, {1'(win), a_source[win]}, a_address[win]);
                end
            end
            checks++;
            if (a_ready !== {(ev && win == 1 && out_a_ready), (ev && win == 0 && out_a_ready)}) begin
                errors++;
                $display("FAIL rand_a_ready cyc=%0d got=%b required=%b", cyc, a_ready,
                         {(ev && win == 1 && out_a_ready), (ev && win == 0 && out_a_ready)});
            end
            checks++;
            if (ind_valid !== {(dv && idx == 1), (dv && idx == 0)} || out_d_ready !== ind_ready[idx]
                || ind_source[0] !== d_source[4:0] || ind_data[1] !== d_data) begin
                errors++;
                $display("FAIL rand_d_route cyc=%0d got dv=%b rdy=%b required dv=%b rdy=%b",
                         cyc, ind_valid, out_d_ready, {(dv && idx == 1), (dv && idx == 0)}, ind_ready[idx]);
            end
            checks++;
            if (d_orphan !== orphan) begin
                errors++;
                $display("FAIL rand_orphan cyc=%0d got=%b required=%b", cyc, d_orphan, orphan);
            end
            afire = ev && out_a_ready;
            dfire = dv && ind_ready[idx];
            old[0] = cnt[0]; old[1] = cnt[1];
            if (afire) cnt[win]++;
            if (dfire) begin
                if (old[idx] == 0 && !(afire && win == idx)) orphan = 1'b1;
                else cnt[idx]--;
            end
            held = (ev && !out_a_ready) ? win : -1;
            if (afire) last = win;
            tick();
        end
        clr();
    endtask

    initial begin
        reset = 1'b1;
        clr();
        test_reset();
        test_round_robin();
        test_stall();
        test_throttle();
        test_d_route();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
